codificador_teclado: RTL

//   Keypad-entry encoder for the microwave timer: the inverse of the BCD-to-7-segment decoder.
//   - Input: raw 10-key one-hot keypad.
//   - Synchronises and debounces each key, then encodes it to BCD.
//   - Shifts each digit into an M:SS entry register from the right, like a calculator.
//   - Outputs min/sec_tens/sec_ones in the same BCD format the decoder consumes.

---
 rtl/codificador_teclado_pkg.sv | 19 +
 rtl/sincronizador_2ff.sv | 14 +
 rtl/codificador_teclado.sv | 68 ++++++
 3 files changed

// File: rtl/codificador_teclado_pkg.sv
// codificador_teclado_pkg: shared BCD widths, FSM states and keypad helpers
package codificador_teclado_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] MAX_SEC_TENS = 4'd5;
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_DEBOUNCE     = 2'd1,
    ST_WAIT_RELEASE = 2'd2
  } estado_t;
  function automatic logic es_onehot(input logic [9:0] v);
    return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
  endfunction
  function automatic logic [BCD_W-1:0] codifica(input logic [9:0] v);
    logic [BCD_W-1:0] c;
    c = '0;
    for (int k = 0; k < 10; k++) c = c | (v[k] ? BCD_W'(k) : '0);
    return c;
  endfunction
endpackage

// File: rtl/sincronizador_2ff.sv
// sincronizador_2ff: two-flop synchroniser with synchronous active-low reset
module sincronizador_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clk)
    if (!rst_n) {q, meta} <= '0;
    else        {q, meta} <= {meta, d};
endmodule

// File: rtl/codificador_teclado.sv
// codificador_teclado: debounced 10-key keypad encoder shifting BCD digits into an M:SS entry
module codificador_teclado
  import codificador_teclado_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       keypad,
  input  logic             load_en,
  input  logic             clear_in,
  output logic [BCD_W-1:0] min,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             digit_valid,
  output logic             entry_nonzero
);
  logic [9:0]       keypad_s;
  estado_t          estado;
  logic [BCD_W-1:0] code;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       warm;
  logic             armed;
  sincronizador_2ff #(.W(10)) u_sync (.clk(clk), .rst_n(rst_n), .d(keypad), .q(keypad_s));
  assign entry_nonzero = |{min, sec_tens, sec_ones};
  // a key already held through reset must be seen released before it can be captured
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {min, sec_tens, sec_ones} <= '0;
      digit_valid <= 1'b0;
      estado <= ST_IDLE;
      code <= '0;
      cnt <= '0;
      warm <= '0;
      armed <= 1'b0;
    end else begin
      warm <= {warm[0], 1'b1};
      armed <= armed | (warm[1] & ~|keypad_s);
      digit_valid <= 1'b0;
      if (clear_in) begin
        {min, sec_tens, sec_ones} <= '0;
        estado <= ST_WAIT_RELEASE;
      end else begin
        case (estado)
          ST_IDLE:
            if (armed && load_en && es_onehot(keypad_s)) begin
              code <= codifica(keypad_s);
              cnt <= CNT_W'(1);
              estado <= ST_DEBOUNCE;
            end
          ST_DEBOUNCE:
            if (keypad_s != (10'd1 << code) || !load_en) estado <= ST_WAIT_RELEASE;
            else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
              min <= sec_tens;
              sec_tens <= (sec_ones > MAX_SEC_TENS) ? MAX_SEC_TENS : sec_ones;
              sec_ones <= code;
              digit_valid <= 1'b1;
              estado <= ST_WAIT_RELEASE;
            end else cnt <= cnt + 1'b1;
          ST_WAIT_RELEASE:
            if (~|keypad_s) estado <= ST_IDLE;
          default: estado <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
